instr_mem_ctrl: RTL

//  Parametrised instruction memory for the MIPS core, with a separate program-load write port and a core fetch port.

---
 rtl/instr_mem_ctrl_pkg.sv | 35 +++
 rtl/instr_mem_ctrl_if.sv | 33 +++
 rtl/instr_mem_ctrl_array.sv | 29 ++
 rtl/instr_mem_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared types and helpers for the instruction memory controller:
// state encoding, default NOP word and the address legality check.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Returns {misalign, range}. Bits below lsb_w are the byte offset; bits from
    // lsb_w+idx_w up to addr_w-1 lie above the word index and must be zero.
    function automatic logic [1:0] addr_check(input logic [63:0] addr,
                                              input int          addr_w,
                                              input int          lsb_w,
                                              input int          idx_w);
        logic misalign_v;
        logic range_v;
        misalign_v = 1'b0;
        range_v    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < lsb_w) begin
                misalign_v = misalign_v | addr[i];
            end else if ((i >= lsb_w + idx_w) && (i < addr_w)) begin
                range_v = range_v | addr[i];
            end else begin
                range_v = range_v;
            end
        end
        return {misalign_v, range_v};
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Bus bundle between the program loader / fetch unit (master) and the
// instruction memory controller (slave).
interface instr_mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) ();

    logic                     load_mode;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_err;
    logic [$clog2(DEPTH):0]   load_count;
    logic                     fetch_req;
    logic                     fetch_ready;
    logic [ADDR_W-1:0]        pc;
    logic [DATA_W-1:0]        inst;
    logic                     inst_valid;
    logic                     fetch_err;

    modport master (
        output load_mode, wr_valid, wr_addr, wr_data, fetch_req, pc,
        input  wr_ready, wr_err, load_count, fetch_ready, inst, inst_valid, fetch_err
    );

    modport slave (
        input  load_mode, wr_valid, wr_addr, wr_data, fetch_req, pc,
        output wr_ready, wr_err, load_count, fetch_ready, inst, inst_valid, fetch_err
    );

endinterface

// File: rtl/instr_mem_ctrl_array.sv
// Single-port synchronous RAM for instruction words: one write or one read
// per cycle, read data registered (read-first). Contents are never reset.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Array write and registered read of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: LOAD/RUN state machine that hands the single
// array port to either the program loader or the fetch path, with error flags.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_ctrl_if.slave   bus
);

    localparam int WB    = DATA_W / 8;
    localparam int WB_LG = $clog2(WB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_t              state_r;
    logic [CNT_W-1:0]    load_count_r;
    logic                wr_err_r;
    logic                inst_valid_r;
    logic                fetch_err_r;
    logic [DATA_W-1:0]   inst_hold_r;

    logic                wr_ready_s;
    logic                fetch_ready_s;
    logic                wr_acc_s;
    logic                fetch_acc_s;
    logic [1:0]          wr_chk_s;
    logic [1:0]          fe_chk_s;
    logic                wr_good_s;
    logic                fe_bad_s;
    logic                arr_we_s;
    logic [IDX_W-1:0]    arr_addr_s;
    logic [DATA_W-1:0]   arr_rdata_s;
    logic [DATA_W-1:0]   inst_s;

    assign wr_chk_s  = addr_check(64'(bus.wr_addr), ADDR_W, WB_LG, IDX_W);
    assign fe_chk_s  = addr_check(64'(bus.pc), ADDR_W, WB_LG, IDX_W);
    assign wr_good_s = (wr_chk_s == 2'b00);
    assign fe_bad_s  = (fe_chk_s != 2'b00);

    // Handshake readiness follows the state; both are held low during reset
    always_comb begin
        wr_ready_s    = 1'b0;
        fetch_ready_s = 1'b0;
        if (rst) begin
            wr_ready_s    = 1'b0;
            fetch_ready_s = 1'b0;
        end else begin
            wr_ready_s    = (state_r == S_LOAD);
            fetch_ready_s = (state_r == S_RUN);
        end
    end

    assign wr_acc_s    = bus.wr_valid & wr_ready_s;
    assign fetch_acc_s = bus.fetch_req & fetch_ready_s;

    // Array port arbitration: the loader owns it in LOAD, the fetch path otherwise
    always_comb begin
        arr_we_s   = 1'b0;
        arr_addr_s = bus.pc[WB_LG +: IDX_W];
        if (state_r == S_LOAD) begin
            arr_we_s   = wr_acc_s & wr_good_s;
            arr_addr_s = bus.wr_addr[WB_LG +: IDX_W];
        end else begin
            arr_we_s   = 1'b0;
            arr_addr_s = bus.pc[WB_LG +: IDX_W];
        end
    end

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .addr  (arr_addr_s),
        .wdata (bus.wr_data),
        .rdata (arr_rdata_s)
    );

    // Mode FSM, saturating load counter and write-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            load_count_r <= {CNT_W{1'b0}};
            wr_err_r     <= 1'b0;
        end else begin
            wr_err_r <= wr_acc_s & ~wr_good_s;
            case (state_r)
                S_IDLE: begin
                    if (bus.load_mode) begin
                        state_r      <= S_LOAD;
                        load_count_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (!bus.load_mode) begin
                        state_r <= S_RUN;
                    end else begin
                        state_r <= S_LOAD;
                    end
                    if (wr_acc_s && wr_good_s && (load_count_r < CNT_W'(DEPTH))) begin
                        load_count_r <= load_count_r + CNT_W'(1);
                    end else begin
                        load_count_r <= load_count_r;
                    end
                end
                S_RUN: begin
                    if (bus.load_mode) begin
                        state_r      <= S_LOAD;
                        load_count_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    load_count_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Fetch return flags; a fetch accepted in the last RUN cycle still returns
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid_r <= 1'b0;
            fetch_err_r  <= 1'b0;
            inst_hold_r  <= NOP_WORD;
        end else begin
            inst_valid_r <= fetch_acc_s;
            fetch_err_r  <= fetch_acc_s & fe_bad_s;
            inst_hold_r  <= inst_s;
        end
    end

    // Fresh word from the array on a good fetch, NOP on a faulted one, else hold
    always_comb begin
        inst_s = inst_hold_r;
        if (!inst_valid_r) begin
            inst_s = inst_hold_r;
        end else if (fetch_err_r) begin
            inst_s = NOP_WORD;
        end else begin
            inst_s = arr_rdata_s;
        end
    end

    assign bus.wr_ready    = wr_ready_s;
    assign bus.fetch_ready = fetch_ready_s;
    assign bus.wr_err      = wr_err_r;
    assign bus.load_count  = load_count_r;
    assign bus.inst        = inst_s;
    assign bus.inst_valid  = inst_valid_r;
    assign bus.fetch_err   = fetch_err_r;

endmodule
